// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger pulse generator and the trigger detector:
// FSM state encoding and the timebase prescaler end-count lookup.
package trigger_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int PRESC_W   = 24;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DELAY  = ST_DELAY,
    ACTIVE = ST_ACTIVE,
    GAP    = ST_GAP
  } pgen_state_t;

  // Prescaler terminal count for one timebase unit; a unit lasts end_cnt+1 clocks.
  // At 12MHz the three finest codes cannot be resolved and all collapse to 1us.
  function automatic logic [PRESC_W-1:0] end_time_base_cnt(input logic [2:0] time_base,
                                                           input logic       is_12mhz);
    logic [PRESC_W-1:0] cnt;
    if (is_12mhz) begin
      case (time_base)
        3'd3:    cnt = 24'd119;
        3'd4:    cnt = 24'd1199;
        3'd5:    cnt = 24'd11999;
        3'd6:    cnt = 24'd119999;
        3'd7:    cnt = 24'd1199999;
        default: cnt = 24'd11;
      endcase
    end else begin
      case (time_base)
        3'd0:    cnt = 24'd0;
        3'd1:    cnt = 24'd9;
        3'd2:    cnt = 24'd99;
        3'd3:    cnt = 24'd999;
        3'd4:    cnt = 24'd9999;
        3'd5:    cnt = 24'd99999;
        3'd6:    cnt = 24'd999999;
        default: cnt = 24'd9999999;
      endcase
    end
    return cnt;
  endfunction

endpackage

// File: rtl/trigger_pulse_gen_if.sv
// Request/config/status bundle of the trigger pulse generator.
// master drives start and configuration; slave is the generator itself.
interface trigger_pulse_gen_if
  import trigger_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic             cfg_enable;
  logic             cfg_positive;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [CNT_W-1:0] cfg_repeat;
  logic [2:0]       cfg_time_base;
  logic             cfg_12mhz;
  logic             pulse_out;
  logic             busy;
  logic             done;

  modport master (
    output start, cfg_enable, cfg_positive, cfg_delay, cfg_width, cfg_gap,
           cfg_repeat, cfg_time_base, cfg_12mhz,
    input  pulse_out, busy, done
  );

  modport slave (
    input  start, cfg_enable, cfg_positive, cfg_delay, cfg_width, cfg_gap,
           cfg_repeat, cfg_time_base, cfg_12mhz,
    output pulse_out, busy, done
  );

endinterface

// File: rtl/time_base_tick.sv
// 24-bit prescaler producing one tick per timebase unit (end_cnt+1 clocks).
// Held at zero while disabled or cleared so each phase starts on a unit boundary.
module time_base_tick
  import trigger_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n_sync,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] end_cnt,
  output logic               tick
);

  logic [PRESC_W-1:0] presc;

  assign tick = en && (presc == end_cnt);

  // Count clocks within the current unit, wrapping to zero on each tick.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      presc <= '0;
    end else if (clr || !en || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/trigger_pulse_gen.sv
// Trigger pulse generator: on start, emits delay -> pulse -> gap -> pulse ...
// using the detector's timebase encoding. An accepted start is registered for one
// clock, so the sequence (busy, first output level) begins on the following edge.
module trigger_pulse_gen
  import trigger_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
)(
  input  logic                clk,
  input  logic                rst_n_sync,
  trigger_pulse_gen_if.slave  bus
);

  pgen_state_t        state;
  logic               launch_pending;
  logic               pos_q;
  logic [CNT_W-1:0]   delay_q;
  logic [CNT_W-1:0]   width_q;
  logic [CNT_W-1:0]   gap_q;
  logic [CNT_W-1:0]   repeat_q;
  logic [2:0]         time_base_q;
  logic               mhz12_q;
  logic [CNT_W-1:0]   unit_cnt;
  logic [CNT_W-1:0]   pulses_left;
  logic               pulse_q;
  logic               done_q;

  logic [PRESC_W-1:0] end_cnt;
  logic               tick;
  logic               accept;
  logic               launch_go;
  logic               abort;
  logic [CNT_W-1:0]   width_eff;
  logic [CNT_W-1:0]   gap_eff;
  logic [CNT_W-1:0]   phase_last;
  logic               phase_done;

  assign end_cnt    = end_time_base_cnt(time_base_q, mhz12_q);
  assign accept     = bus.start && bus.cfg_enable && (state == IDLE) && !launch_pending;
  assign launch_go  = launch_pending && bus.cfg_enable;
  assign abort      = (state != IDLE) && !bus.cfg_enable;
  assign width_eff  = (width_q == '0) ? CNT_W'(1) : width_q;
  assign gap_eff    = (gap_q == '0) ? CNT_W'(1) : gap_q;
  assign phase_done = tick && (unit_cnt == phase_last);

  // Index of the last unit of the current phase (phase length minus one).
  always_comb begin
    phase_last = '0;
    case (state)
      DELAY:   phase_last = delay_q - CNT_W'(1);
      ACTIVE:  phase_last = width_eff - CNT_W'(1);
      GAP:     phase_last = gap_eff - CNT_W'(1);
      default: phase_last = '0;
    endcase
  end

  time_base_tick u_tick (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .clr        (launch_go || phase_done),
    .en         (state != IDLE),
    .end_cnt    (end_cnt),
    .tick       (tick)
  );

  // Capture the whole configuration on an accepted start so later cfg changes are inert.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      launch_pending <= 1'b0;
      pos_q          <= 1'b0;
      delay_q        <= '0;
      width_q        <= '0;
      gap_q          <= '0;
      repeat_q       <= '0;
      time_base_q    <= '0;
      mhz12_q        <= 1'b0;
    end else begin
      launch_pending <= accept;
      if (accept) begin
        pos_q       <= bus.cfg_positive;
        delay_q     <= bus.cfg_delay;
        width_q     <= bus.cfg_width;
        gap_q       <= bus.cfg_gap;
        repeat_q    <= bus.cfg_repeat;
        time_base_q <= bus.cfg_time_base;
        mhz12_q     <= bus.cfg_12mhz;
      end
    end
  end

  // Sequence FSM with unit counter, remaining-pulse counter and registered output level.
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state       <= IDLE;
      unit_cnt    <= '0;
      pulses_left <= '0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        unit_cnt    <= '0;
        pulses_left <= '0;
        pulse_q     <= ~pos_q;
      end else begin
        case (state)
          IDLE: begin
            if (launch_go) begin
              unit_cnt    <= '0;
              pulses_left <= repeat_q;
              if (delay_q != '0) begin
                state   <= DELAY;
                pulse_q <= ~pos_q;
              end else begin
                state   <= ACTIVE;
                pulse_q <= pos_q;
              end
            end else begin
              pulse_q <= ~bus.cfg_positive;
            end
          end
          DELAY: begin
            if (phase_done) begin
              state    <= ACTIVE;
              pulse_q  <= pos_q;
              unit_cnt <= '0;
            end else if (tick) begin
              unit_cnt <= unit_cnt + CNT_W'(1);
            end
          end
          ACTIVE: begin
            if (phase_done) begin
              pulse_q  <= ~pos_q;
              unit_cnt <= '0;
              if (pulses_left == '0) begin
                state  <= IDLE;
                done_q <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else if (tick) begin
              unit_cnt <= unit_cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (phase_done) begin
              state    <= ACTIVE;
              pulse_q  <= pos_q;
              unit_cnt <= '0;
              if (pulses_left != '0) begin
                pulses_left <= pulses_left - CNT_W'(1);
              end
            end else if (tick) begin
              unit_cnt <= unit_cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Scoreboard bench for trigger_pulse_gen: each launched sequence pushes its expected
// busy/pulse/done/busy-fall events, computed from timing arithmetic; a monitor turns the
// DUT waveform into the same events and compares them in order.
module tb_trigger_pulse_gen;
  import trigger_pkg::*;

  localparam int CNT_W = 8;

  typedef enum int {EV_BUSY_RISE, EV_PULSE, EV_DONE, EV_BUSY_FALL} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       len;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n_sync = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  exp_q[$];
  bit   mon_on = 1'b0;
  bit   exp_pos = 1'b1;
  bit   in_run = 1'b0;
  bit   prev_busy = 1'b0;
  bit   act = 1'b0;
  int   run_start = 0;

  trigger_pulse_gen_if #(.CNT_W(CNT_W)) bus ();

  trigger_pulse_gen #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unit length in clocks from the clock period: 10ns at 100MHz, 1us = 12 clocks at 12MHz.
  function automatic int unit_clocks(input int tbase, input bit m12);
    int u;
    u = 1;
    if (!m12) begin
      for (int i = 0; i < tbase; i++) u = u * 10;
    end else begin
      u = 12;
      for (int i = 3; i <= tbase; i++) u = u * 10;
    end
    return u;
  endfunction

  task automatic check_output(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
    end
  endtask

  task automatic observe(input ev_kind_t k, input int c, input int l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_%s: got cyc=%0d len=%0d, required no event", k.name(), c, l);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.cyc != c || (k == EV_PULSE && e.len != l)) begin
      errors++;
      $display("[TB] FAIL event: got %s cyc=%0d len=%0d, required %s cyc=%0d len=%0d",
               k.name(), c, l, e.kind.name(), e.cyc, e.len);
    end
  endtask

  // Monitor: converts the waveform into events, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        act = bus.busy && (bus.pulse_out == exp_pos);
        if (bus.busy && !prev_busy) observe(EV_BUSY_RISE, cyc, 0);
        if (in_run && !act) begin
          observe(EV_PULSE, run_start, cyc - run_start);
          in_run = 1'b0;
        end else if (!in_run && act) begin
          in_run = 1'b1;
          run_start = cyc;
        end
        if (bus.done) observe(EV_DONE, cyc, 0);
        if (!bus.busy && prev_busy) observe(EV_BUSY_FALL, cyc, 0);
        prev_busy = bus.busy;
      end
    end
  end

  task automatic wait_for_cycle(input int target);
    for (int i = 0; i < 100000 && cyc < target; i++) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_stimulus(input bit pos, input int d, input int w, input int g, input int r,
                                input int tbase, input bit m12, input int abort_off,
                                input bit scramble);
    int u, we, ge, e_cyc, t0, done_c, a, s, e;
    u  = unit_clocks(tbase, m12);
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    @(negedge clk);
    bus.cfg_enable    = 1'b1;
    bus.cfg_positive  = pos;
    bus.cfg_delay     = CNT_W'(d);
    bus.cfg_width     = CNT_W'(w);
    bus.cfg_gap       = CNT_W'(g);
    bus.cfg_repeat    = CNT_W'(r);
    bus.cfg_time_base = 3'(tbase);
    bus.cfg_12mhz     = m12;
    bus.start         = 1'b1;
    e_cyc  = cyc + 2;
    t0     = e_cyc + d * u;
    done_c = t0 + ((r + 1) * we + r * ge) * u;
    a = -1;
    if (abort_off > 0 && done_c - e_cyc >= 2) a = e_cyc + 1 + (abort_off % (done_c - e_cyc - 1));
    exp_pos = pos;
    exp_q.push_back('{kind: EV_BUSY_RISE, cyc: e_cyc, len: 0});
    for (int i = 0; i <= r; i++) begin
      s = t0 + i * (we + ge) * u;
      e = s + we * u;
      if (a >= 0 && a <= s) break;
      if (a >= 0 && a < e) begin
        exp_q.push_back('{kind: EV_PULSE, cyc: s, len: a - s});
        break;
      end
      exp_q.push_back('{kind: EV_PULSE, cyc: s, len: we * u});
    end
    if (a >= 0) begin
      exp_q.push_back('{kind: EV_BUSY_FALL, cyc: a, len: 0});
    end else begin
      exp_q.push_back('{kind: EV_DONE, cyc: done_c, len: 0});
      exp_q.push_back('{kind: EV_BUSY_FALL, cyc: done_c, len: 0});
    end
    @(negedge clk);
    bus.start = 1'b0;
    if (scramble) begin
      for (int k = 0; k < 3; k++) begin
        repeat ($urandom_range(2, 6)) @(negedge clk);
        if (cyc + 1 < done_c) begin
          bus.cfg_positive  = 1'($urandom_range(0, 1));
          bus.cfg_delay     = CNT_W'($urandom_range(0, 255));
          bus.cfg_width     = CNT_W'($urandom_range(0, 255));
          bus.cfg_gap       = CNT_W'($urandom_range(0, 255));
          bus.cfg_repeat    = CNT_W'($urandom_range(0, 255));
          bus.cfg_time_base = 3'($urandom_range(0, 7));
          bus.cfg_12mhz     = 1'($urandom_range(0, 1));
          bus.start         = 1'b1;
          @(negedge clk);
          bus.start = 1'b0;
        end
      end
    end
    if (a >= 0) begin
      wait_for_cycle(a - 1);
      bus.cfg_enable = 1'b0;
      @(negedge clk);
      bus.cfg_enable = 1'b1;
    end
    wait_drain(done_c - cyc + 64);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int m12, tbase, u, d, w, g, r, ab, sc;
    bus.start = 1'b0;
    bus.cfg_enable = 1'b1;
    bus.cfg_positive = 1'b0;
    bus.cfg_delay = '0;
    bus.cfg_width = '0;
    bus.cfg_gap = '0;
    bus.cfg_repeat = '0;
    bus.cfg_time_base = '0;
    bus.cfg_12mhz = 1'b0;

    // Reset values hold regardless of cfg_positive; after release the idle level applies.
    repeat (3) @(negedge clk);
    check_output("reset_pulse_out", bus.pulse_out, 1'b0);
    check_output("reset_busy", bus.busy, 1'b0);
    check_output("reset_done", bus.done, 1'b0);
    rst_n_sync = 1'b1;
    @(negedge clk);
    check_output("idle_level_neg", bus.pulse_out, 1'b1);
    bus.cfg_positive = 1'b1;
    @(negedge clk);
    check_output("idle_level_pos", bus.pulse_out, 1'b0);
    mon_on = 1'b1;

    $display("[TB] directed sequences");
    apply_stimulus(1, 0, 3, 0, 0, 1, 0, 0, 0);
    apply_stimulus(0, 2, 1, 0, 2, 0, 0, 0, 0);
    apply_stimulus(1, 1, 2, 1, 1, 0, 1, 0, 0);
    apply_stimulus(1, 1, 2, 1, 1, 2, 1, 0, 0);
    apply_stimulus(1, 0, 1, 1, 0, 3, 1, 0, 0);
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(1, 1, 3, 2, 2, 1, 0, 0, 1);
    apply_stimulus(1, 0, 5, 0, 0, 1, 0, 20, 0);
    apply_stimulus(0, 0, 1, 1, 255, 0, 0, 0, 0);
    apply_stimulus(1, 0, 255, 0, 0, 0, 0, 0, 0);

    // Start while disabled must be ignored.
    @(negedge clk);
    bus.cfg_enable = 1'b0;
    bus.cfg_positive = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check_output("disabled_busy", bus.busy, 1'b0);
    check_output("disabled_level", bus.pulse_out, 1'b1);
    bus.cfg_enable = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] random sequences");
    for (int n = 0; n < 24; n++) begin
      m12   = $urandom_range(0, 1);
      tbase = (m12 != 0) ? $urandom_range(0, 3) : $urandom_range(0, 2);
      u     = unit_clocks(tbase, m12 != 0);
      if (u >= 100) begin
        d = $urandom_range(0, 1); w = $urandom_range(0, 1);
        g = $urandom_range(0, 1); r = $urandom_range(0, 1);
      end else if (u >= 10) begin
        d = $urandom_range(0, 3); w = $urandom_range(0, 3);
        g = $urandom_range(0, 3); r = $urandom_range(0, 3);
      end else begin
        d = $urandom_range(0, 8); w = $urandom_range(0, 8);
        g = $urandom_range(0, 8); r = $urandom_range(0, 6);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 400) : 0;
      sc = (ab == 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
      apply_stimulus(1'($urandom_range(0, 1)), d, w, g, r, tbase, m12 != 0, ab, sc != 0);
    end

    // Asynchronous reset in the middle of an active pulse clears everything at once.
    mon_on = 1'b0;
    @(negedge clk);
    bus.cfg_positive = 1'b1;
    bus.cfg_delay = '0;
    bus.cfg_width = CNT_W'(200);
    bus.cfg_repeat = '0;
    bus.cfg_time_base = 3'd0;
    bus.cfg_12mhz = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check_output("mid_pulse_level", bus.pulse_out, 1'b1);
    check_output("mid_pulse_busy", bus.busy, 1'b1);
    #2;
    rst_n_sync = 1'b0;
    #1;
    check_output("async_reset_pulse_out", bus.pulse_out, 1'b0);
    check_output("async_reset_busy", bus.busy, 1'b0);
    check_output("async_reset_done", bus.done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n_sync = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
